// File: rtl/msrh_disp_rcv_buffer.sv
// Receiving end of the dispatch interface: a small in-order FIFO of dispatch
// groups with first-word-fallthrough output, registered occupancy and flush.
module msrh_disp_rcv_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DISP_SIZE = 5,
  parameter int unsigned DISP_W    = 64,
  parameter int unsigned CMT_BLK_W = 5,
  parameter int unsigned VADDR_W   = 39
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_disp_valid,
  input  logic [CMT_BLK_W-1:0]          i_disp_cmt_id,
  input  logic [VADDR_W-2:0]            i_disp_pc_addr,
  input  logic [DISP_SIZE*DISP_W-1:0]   i_disp_inst,
  output logic                          o_disp_ready,
  output logic                          o_grp_valid,
  output logic [CMT_BLK_W-1:0]          o_grp_cmt_id,
  output logic [VADDR_W-2:0]            o_grp_pc_addr,
  output logic [DISP_SIZE*DISP_W-1:0]   o_grp_inst,
  input  logic                          i_grp_ready,
  input  logic                          i_flush_valid,
  output logic [$clog2(DEPTH+1)-1:0]    o_count
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH+1);
  localparam int unsigned INST_W = DISP_SIZE * DISP_W;

  logic [CMT_BLK_W-1:0] cmt_id_mem [DEPTH];
  logic [VADDR_W-2:0]   pc_mem     [DEPTH];
  logic [INST_W-1:0]    inst_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             enq;
  logic             deq;

  // Ready depends only on the registered count, so a dequeue in the full
  // cycle does not open the door until the following cycle.
  assign o_disp_ready = (count < CNT_W'(DEPTH));
  assign o_grp_valid  = (count != '0);
  assign o_count      = count;

  assign enq = i_disp_valid & o_disp_ready & ~i_flush_valid;
  assign deq = o_grp_valid & i_grp_ready & ~i_flush_valid;

  always_ff @(posedge i_clk) begin
    if (enq) begin
      cmt_id_mem[wr_ptr] <= i_disp_cmt_id;
      pc_mem[wr_ptr]     <= i_disp_pc_addr;
      inst_mem[wr_ptr]   <= i_disp_inst;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign o_grp_cmt_id  = cmt_id_mem[rd_ptr];
  assign o_grp_pc_addr = pc_mem[rd_ptr];
  assign o_grp_inst    = inst_mem[rd_ptr];

  // A stalled master must keep its offer unchanged until it is accepted.
  disp_hold_stable: assert property (
    @(posedge i_clk) disable iff (!i_reset_n)
    (i_disp_valid && !o_disp_ready) |=>
      (i_disp_valid && $stable(i_disp_cmt_id) && $stable(i_disp_pc_addr) &&
       $stable(i_disp_inst))
  );

endmodule

// File: tb/tb_msrh_disp_rcv_buffer.sv
// Directed and constrained-random bench for msrh_disp_rcv_buffer against a
// queue-based model of the group FIFO.
module tb_msrh_disp_rcv_buffer;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned DISP_SIZE = 5;
  localparam int unsigned DISP_W    = 64;
  localparam int unsigned CMT_BLK_W = 5;
  localparam int unsigned VADDR_W   = 39;
  localparam int unsigned INST_W    = DISP_SIZE * DISP_W;
  localparam int unsigned CNT_W     = $clog2(DEPTH+1);

  logic                 i_clk = 1'b0;
  logic                 i_reset_n = 1'b0;
  logic                 i_disp_valid = 1'b0;
  logic [CMT_BLK_W-1:0] i_disp_cmt_id = '0;
  logic [VADDR_W-2:0]   i_disp_pc_addr = '0;
  logic [INST_W-1:0]    i_disp_inst = '0;
  logic                 o_disp_ready;
  logic                 o_grp_valid;
  logic [CMT_BLK_W-1:0] o_grp_cmt_id;
  logic [VADDR_W-2:0]   o_grp_pc_addr;
  logic [INST_W-1:0]    o_grp_inst;
  logic                 i_grp_ready = 1'b0;
  logic                 i_flush_valid = 1'b0;
  logic [CNT_W-1:0]     o_count;

  msrh_disp_rcv_buffer #(
    .DEPTH(DEPTH), .DISP_SIZE(DISP_SIZE), .DISP_W(DISP_W),
    .CMT_BLK_W(CMT_BLK_W), .VADDR_W(VADDR_W)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_disp_valid(i_disp_valid), .i_disp_cmt_id(i_disp_cmt_id),
    .i_disp_pc_addr(i_disp_pc_addr), .i_disp_inst(i_disp_inst),
    .o_disp_ready(o_disp_ready), .o_grp_valid(o_grp_valid),
    .o_grp_cmt_id(o_grp_cmt_id), .o_grp_pc_addr(o_grp_pc_addr),
    .o_grp_inst(o_grp_inst), .i_grp_ready(i_grp_ready),
    .i_flush_valid(i_flush_valid), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [CMT_BLK_W-1:0] id;
    logic [VADDR_W-2:0]   pc;
    logic [INST_W-1:0]    inst;
  } grp_t;

  grp_t mq[$];
  int   vectors = 0;
  int   errors  = 0;

  task automatic chk(input string name, input logic [INST_W-1:0] act,
                     input logic [INST_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Outputs settle after the rising edge; the falling edge is a quiet point.
  always @(negedge i_clk) begin
    chk("count", INST_W'(o_count), INST_W'(mq.size()));
    chk("disp_ready", INST_W'(o_disp_ready), INST_W'(mq.size() < DEPTH));
    chk("grp_valid", INST_W'(o_grp_valid), INST_W'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("head_id", INST_W'(o_grp_cmt_id), INST_W'(mq[0].id));
      chk("head_pc", INST_W'(o_grp_pc_addr), INST_W'(mq[0].pc));
      chk("head_inst", o_grp_inst, mq[0].inst);
    end
  end

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic cycle();
    bit   rdy;
    bit   enq;
    bit   deq;
    grp_t g;
    rdy    = mq.size() < DEPTH;
    enq    = i_disp_valid && rdy && !i_flush_valid;
    deq    = (mq.size() != 0) && i_grp_ready && !i_flush_valid;
    g.id   = i_disp_cmt_id;
    g.pc   = i_disp_pc_addr;
    g.inst = i_disp_inst;
    @(posedge i_clk);
    if (i_flush_valid) mq.delete();
    else begin
      if (deq) void'(mq.pop_front());
      if (enq) mq.push_back(g);
    end
    #1;
  endtask

  function automatic logic [INST_W-1:0] mk_inst(input int unsigned tag);
    logic [INST_W-1:0] v;
    for (int unsigned k = 0; k < DISP_SIZE; k++)
      v[k*DISP_W +: DISP_W] = {32'(tag), 16'hC0DE, 16'(k)};
    return v;
  endfunction

  task automatic offer(input int unsigned id);
    i_disp_valid   = 1'b1;
    i_disp_cmt_id  = CMT_BLK_W'(id);
    i_disp_pc_addr = (VADDR_W-1)'(id * 4 + 'h200);
    i_disp_inst    = mk_inst(id);
  endtask

  initial begin
    logic [INST_W-1:0] a5;
    int unsigned       seq;
    bit                hold;

    // reset state, asserted with no clock edge yet
    #2;
    chk("rst_count", INST_W'(o_count), '0);
    chk("rst_ready", INST_W'(o_disp_ready), INST_W'(1));
    chk("rst_valid", INST_W'(o_grp_valid), '0);
    #5 i_reset_n = 1'b1;
    @(posedge i_clk); #1;

    // single group
    a5 = '0;
    a5[63:0] = 64'hA5;
    i_disp_valid = 1'b1; i_disp_cmt_id = 5'd3; i_disp_pc_addr = 38'h100;
    i_disp_inst = a5; i_grp_ready = 1'b0;
    cycle();
    i_disp_valid = 1'b0;
    chk("single_valid", INST_W'(o_grp_valid), INST_W'(1));
    chk("single_id", INST_W'(o_grp_cmt_id), INST_W'(3));
    chk("single_pc", INST_W'(o_grp_pc_addr), INST_W'(38'h100));
    chk("single_inst", o_grp_inst, a5);
    chk("single_count", INST_W'(o_count), INST_W'(1));
    i_grp_ready = 1'b1;
    cycle();
    i_grp_ready = 1'b0;
    chk("single_drain_valid", INST_W'(o_grp_valid), '0);
    chk("single_drain_count", INST_W'(o_count), '0);

    // fill to full, then offer while full with a dequeue
    for (int unsigned i = 0; i < 4; i++) begin
      offer(i);
      cycle();
    end
    i_disp_valid = 1'b0;
    chk("full_count", INST_W'(o_count), INST_W'(4));
    chk("full_ready", INST_W'(o_disp_ready), '0);
    offer(4); i_grp_ready = 1'b1;
    cycle();
    chk("full_deq_count", INST_W'(o_count), INST_W'(3));
    chk("full_deq_ready", INST_W'(o_disp_ready), INST_W'(1));
    chk("full_deq_head", INST_W'(o_grp_cmt_id), INST_W'(1));
    i_grp_ready = 1'b0;
    cycle();
    i_disp_valid = 1'b0;
    chk("full_refill", INST_W'(o_count), INST_W'(4));
    i_grp_ready = 1'b1;
    for (int unsigned k = 1; k <= 4; k++) begin
      chk("full_order", INST_W'(o_grp_cmt_id), INST_W'(k));
      cycle();
    end
    i_grp_ready = 1'b0;

    // simultaneous enqueue/dequeue at occupancy 2 across pointer wraps
    offer(10); cycle();
    offer(11); cycle();
    i_grp_ready = 1'b1;
    for (int unsigned i = 12; i < 22; i++) begin
      offer(i);
      cycle();
      chk("stream_count", INST_W'(o_count), INST_W'(2));
    end
    i_disp_valid = 1'b0;
    chk("stream_head", INST_W'(o_grp_cmt_id), INST_W'(20));
    cycle(); cycle();
    i_grp_ready = 1'b0;

    // flush with concurrent enqueue and dequeue
    offer(30); cycle();
    offer(31); cycle();
    offer(29); cycle();
    offer(7); i_grp_ready = 1'b1; i_flush_valid = 1'b1;
    cycle();
    i_flush_valid = 1'b0; i_disp_valid = 1'b0; i_grp_ready = 1'b0;
    chk("flush_count", INST_W'(o_count), '0);
    chk("flush_valid", INST_W'(o_grp_valid), '0);
    offer(8); cycle();
    i_disp_valid = 1'b0;
    chk("flush_next_id", INST_W'(o_grp_cmt_id), INST_W'(8));
    i_grp_ready = 1'b1; cycle(); i_grp_ready = 1'b0;

    // back-to-back flushes from full
    for (int unsigned i = 0; i < 4; i++) begin
      offer(i + 40);
      cycle();
    end
    i_disp_valid = 1'b0;
    i_flush_valid = 1'b1; cycle(); cycle();
    i_flush_valid = 1'b0;
    chk("flush2_ready", INST_W'(o_disp_ready), INST_W'(1));
    chk("flush2_count", INST_W'(o_count), '0);

    // asynchronous reset between edges
    for (int unsigned i = 0; i < 3; i++) begin
      offer(i + 50);
      cycle();
    end
    i_disp_valid = 1'b0;
    #2 i_reset_n = 1'b0;
    mq.delete();
    #1;
    chk("arst_valid", INST_W'(o_grp_valid), '0);
    chk("arst_count", INST_W'(o_count), '0);
    chk("arst_ready", INST_W'(o_disp_ready), INST_W'(1));
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    @(posedge i_clk); #1;

    // random traffic respecting the hold rule
    seq = 1000;
    for (int unsigned c = 0; c < 10000; c++) begin
      hold = i_disp_valid && !(mq.size() < DEPTH);
      cycle();
      if (!hold) begin
        i_disp_valid = ($urandom_range(0, 3) != 0);
        i_disp_cmt_id = CMT_BLK_W'($urandom);
        i_disp_pc_addr = {6'($urandom), 32'($urandom)};
        i_disp_inst = mk_inst(seq);
        seq++;
      end
      i_grp_ready   = ($urandom_range(0, 2) != 0);
      i_flush_valid = ($urandom_range(0, 49) == 0);
    end
    i_disp_valid = 1'b0; i_flush_valid = 1'b0; i_grp_ready = 1'b1;
    cycle(); cycle(); cycle(); cycle(); cycle();
    chk("final_empty", INST_W'(o_count), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/msrh_disp_rcv_buffer.md
Name: msrh_disp_rcv_buffer

Overview:
- Slave (receiving) end of the dispatch interface.
- Accepts dispatch groups (cmt_id, pc_addr, DISP_SIZE instruction slots) from the rename/dispatch master via valid/ready.
- Holds them in a small in-order FIFO and presents them one group at a time to the downstream scheduler-allocation stage.
- Decouples rename stalls from issue-queue backpressure and drops all buffered groups on pipeline flush.

Parameters:
- DEPTH, 4, number of buffered groups; power of two, ≥2.
- DISP_SIZE, 5, instruction slots per group.
- DISP_W, 64, width of one disp_t slot, packed and opaque to this block.
- CMT_BLK_W, 5, commit-block id width.
- VADDR_W, 39, virtual address width; pc_addr carries bits [VADDR_W-1:1].

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_disp_valid  in  1  master offers a group.
- i_disp_cmt_id  in  CMT_BLK_W  group commit id.
- i_disp_pc_addr  in  VADDR_W-1  group pc[VADDR_W-1:1].
- i_disp_inst  in  DISP_SIZE*DISP_W  packed slots, slot 0 in LSBs.
- o_disp_ready  out  1  buffer accepts a group this cycle.
- o_grp_valid  out  1  head group available.
- o_grp_cmt_id  out  CMT_BLK_W  head group commit id.
- o_grp_pc_addr  out  VADDR_W-1  head group pc.
- o_grp_inst  out  DISP_SIZE*DISP_W  head group slots.
- i_grp_ready  in  1  downstream consumes head this cycle.
- i_flush_valid  in  1  discard all buffered groups.
- o_count  out  $clog2(DEPTH+1)  registered occupancy.

Behaviour:
- Clock/reset: single clock domain; i_reset_n asynchronous active-low.
- Reset values: wr_ptr=0, rd_ptr=0, count=0; o_grp_valid=0, o_count=0, o_disp_ready=1. Payload storage is not reset; o_grp_* data is don't-care while o_grp_valid=0.
- o_disp_ready = (count < DEPTH), from registered count only. There is no combinational path from i_grp_ready or i_flush_valid to o_disp_ready.
- Enqueue: enq = i_disp_valid & o_disp_ready & ~i_flush_valid. Writes cmt_id/pc_addr/inst into entry wr_ptr; wr_ptr increments modulo DEPTH.
- Output: first-word-fallthrough from entry rd_ptr; o_grp_valid = (count != 0).
- Dequeue: deq = o_grp_valid & i_grp_ready & ~i_flush_valid; rd_ptr increments modulo DEPTH.
- Latency: a group accepted in cycle N appears on o_grp_* in cycle N+1 at the earliest. There is no same-cycle bypass, even when empty.
- count update: +1 on enq only; −1 on deq only; unchanged on both or neither.
- Full (count=DEPTH): o_disp_ready=0 even if deq fires this cycle. Ready reasserts the next cycle.
- Empty: o_grp_valid=0; i_grp_ready is ignored.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally; ordering is strictly FIFO across wrap.
- Flush: when i_flush_valid=1, the next cycle has count=0, wr_ptr=rd_ptr=0, o_grp_valid=0. Any same-cycle enq or deq is suppressed. The master sees o_disp_ready as computed from the pre-flush count, but the group is dropped.
- Flush with the buffer full: o_disp_ready returns to 1 the cycle after the flush.
- Back-to-back flushes are legal; each leaves the buffer empty.
- Master protocol requirement: i_disp_* is held stable while i_disp_valid=1 and o_disp_ready=0. Violation is flagged by a simulation assertion and is not corrected.
- Payload transparency: output fields are bit-identical to input fields; no reinterpretation of slots.
- Reset mid-operation: an asynchronous assert clears pointers and count immediately; buffered groups are lost.

Test Plan:
- Single group: reset; cycle 1 enqueue cmt_id=3, pc=0x100, slot0=0xA5, i_grp_ready=0 → cycle 2 o_grp_valid=1 with the same fields, o_count=1; raise ready → cycle 3 o_grp_valid=0, o_count=0.
- Fill/full: i_grp_ready=0; enqueue ids 0,1,2,3 on consecutive cycles → o_count=4 and o_disp_ready=0. Offer id 4 with i_grp_ready=1 → id 4 not accepted that cycle, id 0 dequeued. Next cycle o_disp_ready=1 and id 4 accepted; output order is 1,2,3,4.
- Simultaneous enq/deq: hold count=2, stream enqueues with i_grp_ready=1 for 10 cycles → o_count stays 2. Ids exit in order across ≥2 pointer wraps, with no loss or duplication.
- Flush: buffer holding 3 groups, i_flush_valid=1 together with enq of id 7 and i_grp_ready=1 → next cycle o_count=0, o_grp_valid=0. id 7 never appears; a subsequent enqueue of id 8 emerges first.
- Async reset mid-stream: count=3, drop i_reset_n between clock edges → o_grp_valid=0, o_count=0, o_disp_ready=1 immediately, with no clock needed.
- Random valid/ready/flush for 10k cycles → scoreboard ordering matches, o_count stays ≤ DEPTH, and no enqueue is accepted while o_disp_ready=0.
